// File: rtl/colour_freq_sampler.sv
// colour_freq_sampler: drives a TCS3200-style colour sensor through its red,
// green, blue and clear filters, counts freq_in rising edges over a fixed gate
// window per filter, and publishes one consistent set of four counts.
module colour_freq_sampler #(
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             freq_in,
  output logic [3:0]       s,
  output logic             oe_n,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic             overflow
);

  localparam int GT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [GT_W-1:0]  GATE_LAST   = GT_W'(GATE_CYCLES - 1);
  localparam logic [GT_W-1:0]  GATE_ONE    = GT_W'(1);
  localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [ST_W-1:0]  SETTLE_ONE  = ST_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic sync1;
  logic sync2;
  logic sync3;
  logic freq_edge;

  logic [1:0]       idx;
  logic [ST_W-1:0]  settle_tmr;
  logic [GT_W-1:0]  gate_tmr;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] shadow [4];
  logic             ovf_shadow;

  logic settle_done;
  logic gate_done;
  logic start_scan;
  logic bump_ovf;

  // S3,S2 filter code for each index: red, green, blue, clear
  function automatic logic [1:0] filter_sel(input logic [1:0] i);
    case (i)
      2'd0:    filter_sel = 2'b00;
      2'd1:    filter_sel = 2'b11;
      2'd2:    filter_sel = 2'b10;
      default: filter_sel = 2'b01;
    endcase
  endfunction

  assign freq_edge   = sync2 & ~sync3;
  assign settle_done = (state == SETTLE) && (settle_tmr == SETTLE_LAST);
  assign gate_done   = (state == GATE) && (gate_tmr == GATE_LAST);
  assign start_scan  = (state == IDLE) && start && !abort;
  assign bump_ovf    = (state == GATE) && freq_edge && (edge_cnt == CNT_MAX);
  assign cnt_next    = ((state == GATE) && freq_edge && (edge_cnt != CNT_MAX))
                       ? edge_cnt + CNT_ONE : edge_cnt;

  // Bring the asynchronous sensor output into the clk domain and keep one
  // extra stage of history for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= freq_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Scan sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and sensor select decode; abort outranks start in IDLE
  always_comb begin
    next_state = state;
    s          = 4'b0000;
    oe_n       = 1'b1;
    case (state)
      IDLE: begin
        if (start_scan) begin
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        s    = {filter_sel(idx), 2'b01};
        oe_n = 1'b0;
        if (abort) begin
          next_state = IDLE;
        end else if (settle_done) begin
          next_state = GATE;
        end
      end
      GATE: begin
        s    = {filter_sel(idx), 2'b01};
        oe_n = 1'b0;
        if (abort) begin
          next_state = IDLE;
        end else if (gate_done) begin
          next_state = (idx == 2'd3) ? DONE : SETTLE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Timers, edge counter, per-filter shadows and the committed result set;
  // outputs only move when a full scan reaches DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      valid      <= 1'b0;
      idx        <= 2'd0;
      settle_tmr <= '0;
      gate_tmr   <= '0;
      edge_cnt   <= '0;
      ovf_shadow <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= '0;
      end
      red_cnt    <= '0;
      green_cnt  <= '0;
      blue_cnt   <= '0;
      clear_cnt  <= '0;
      overflow   <= 1'b0;
    end else begin
      busy  <= (state != IDLE);
      valid <= (state == DONE);

      if ((state == SETTLE) && !settle_done) begin
        settle_tmr <= settle_tmr + SETTLE_ONE;
      end else begin
        settle_tmr <= '0;
      end

      if ((state == GATE) && !gate_done) begin
        gate_tmr <= gate_tmr + GATE_ONE;
      end else begin
        gate_tmr <= '0;
      end

      if (start_scan) begin
        idx <= 2'd0;
      end else if (gate_done && (idx != 2'd3)) begin
        idx <= idx + 2'd1;
      end

      if (start_scan) begin
        ovf_shadow <= 1'b0;
      end else if (bump_ovf) begin
        ovf_shadow <= 1'b1;
      end

      if (settle_done) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= cnt_next;
      end

      if (gate_done) begin
        shadow[idx] <= cnt_next;
      end

      if (state == DONE) begin
        red_cnt   <= shadow[0];
        green_cnt <= shadow[1];
        blue_cnt  <= shadow[2];
        clear_cnt <= shadow[3];
        overflow  <= ovf_shadow;
      end
    end
  end

endmodule

// File: tb/tb_colour_freq_sampler.sv
// tb_colour_freq_sampler: scoreboard bench for colour_freq_sampler. Instance A
// uses a short gate (100) for functional scans; instance B a long gate (600)
// for saturation. Expected scans are queued at start, monitors pop on valid.
module tb_colour_freq_sampler;

  localparam int CW = 8;

  typedef struct {
    int r;
    int g;
    int b;
    int c;
    int tol;
    int ovf;
    int vcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start_a = 1'b0, abort_a = 1'b0, freq_a = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0, freq_b = 1'b0;
  logic [3:0] s_a, s_b;
  logic oe_a, oe_b, busy_a, busy_b, valid_a, valid_b, ovf_a, ovf_b;
  logic [CW-1:0] red_a, green_a, blue_a, clear_a;
  logic [CW-1:0] red_b, green_b, blue_b, clear_b;

  int cyc = 0;
  int vec_count = 0;
  int miss_count = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int per_by_sel[4] = '{10, 10, 10, 10};
  int per_b = 2;
  int ph_a = 0;
  int ph_b = 0;
  logic [1:0] sel_log[$];
  int s_bad = 0;

  colour_freq_sampler #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .freq_in(freq_a),
    .s(s_a), .oe_n(oe_a), .busy(busy_a), .valid(valid_a),
    .red_cnt(red_a), .green_cnt(green_a), .blue_cnt(blue_a), .clear_cnt(clear_a),
    .overflow(ovf_a)
  );

  colour_freq_sampler #(.GATE_CYCLES(600), .SETTLE_CYCLES(4), .CNT_W(CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .freq_in(freq_b),
    .s(s_b), .oe_n(oe_b), .busy(busy_b), .valid(valid_b),
    .red_cnt(red_b), .green_cnt(green_b), .blue_cnt(blue_b), .clear_cnt(clear_b),
    .overflow(ovf_b)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Count active edges so expected valid cycles can be stated absolutely
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor models: A's period follows the selected filter, B's is global
  always @(negedge clk) begin
    ph_a = ph_a + 1;
    if (ph_a >= per_by_sel[s_a[3:2]]) ph_a = 0;
    freq_a = (ph_a < per_by_sel[s_a[3:2]] / 2);
    ph_b = ph_b + 1;
    if (ph_b >= per_b) ph_b = 0;
    freq_b = (ph_b < per_b / 2);
  end

  // Record filter-select sequence and any bad scaling select on instance A
  always @(negedge clk) begin
    if (oe_a === 1'b0) begin
      if (s_a[1:0] !== 2'b01) s_bad++;
      if (sel_log.size() == 0 || sel_log[$] != s_a[3:2]) sel_log.push_back(s_a[3:2]);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp, input int tol);
    vec_count++;
    if (act < exp - tol || act > exp + tol) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic checkResult(input string tag, input exp_t e, input int r, input int g,
                             input int b, input int c, input int ovf, input int busy);
    checkOutput({tag, " red"}, r, e.r, e.tol);
    checkOutput({tag, " green"}, g, e.g, e.tol);
    checkOutput({tag, " blue"}, b, e.b, e.tol);
    checkOutput({tag, " clear"}, c, e.c, e.tol);
    checkOutput({tag, " overflow"}, ovf, e.ovf, 0);
    checkOutput({tag, " busy_at_valid"}, busy, 1, 0);
    checkOutput({tag, " valid_cycle"}, cyc, e.vcyc, 0);
  endtask

  // Monitor A: every valid pulse must match the oldest queued scan
  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        vec_count++;
        miss_count++;
        $display("[TB] FAIL A unexpected_valid: got valid=1, expected no pulse");
      end else begin
        exp_t e;
        e = q_a.pop_front();
        checkResult("A", e, red_a, green_a, blue_a, clear_a, ovf_a, busy_a);
        @(negedge clk);
        checkOutput("A busy_after_valid", busy_a, 0, 0);
      end
    end
  end

  // Monitor B: same for the saturation instance
  always @(negedge clk) begin
    if (valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        vec_count++;
        miss_count++;
        $display("[TB] FAIL B unexpected_valid: got valid=1, expected no pulse");
      end else begin
        exp_t e;
        e = q_b.pop_front();
        checkResult("B", e, red_b, green_b, blue_b, clear_b, ovf_b, busy_b);
        @(negedge clk);
        checkOutput("B busy_after_valid", busy_b, 0, 0);
      end
    end
  end

  function automatic exp_t mk(input int r, input int g, input int b, input int c,
                              input int tol, input int ovf);
    exp_t e;
    e.r = r; e.g = g; e.b = b; e.c = c; e.tol = tol; e.ovf = ovf; e.vcyc = 0;
    return e;
  endfunction

  // One start pulse; valid expected in the cycle after edge T0+1+4*(S+G)
  task automatic applyStimulus(input bit use_b, input exp_t e);
    @(negedge clk);
    e.vcyc = cyc + 1 + (use_b ? 2417 : 417);
    if (use_b) begin start_b = 1'b1; q_b.push_back(e); end
    else       begin start_a = 1'b1; q_a.push_back(e); end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    checkOutput(use_b ? "B busy_T0+1" : "A busy_T0+1", use_b ? busy_b : busy_a, 1, 0);
  endtask

  task automatic startOnlyA(output int t0);
    @(negedge clk);
    start_a = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitDrain(input bit use_b, input int budget);
    int n = 0;
    while (((use_b ? q_b.size() : q_a.size()) != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((use_b ? q_b.size() : q_a.size()) != 0) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL %s valid_timeout: got no valid in %0d cycles, expected one",
               use_b ? "B" : "A", budget);
      if (use_b) q_b.delete(); else q_a.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, " s"}, s_a, 0, 0);
    checkOutput({tag, " oe_n"}, oe_a, 1, 0);
    checkOutput({tag, " busy"}, busy_a, 0, 0);
    checkOutput({tag, " valid"}, valid_a, 0, 0);
    checkOutput({tag, " red"}, red_a, 0, 0);
    checkOutput({tag, " green"}, green_a, 0, 0);
    checkOutput({tag, " blue"}, blue_a, 0, 0);
    checkOutput({tag, " clear"}, clear_a, 0, 0);
    checkOutput({tag, " overflow"}, ovf_a, 0, 0);
  endtask

  // Directed sequence
  initial begin
    int t0;
    int c0;
    logic [1:0] exp_sel [4];
    exp_sel = '{2'b00, 2'b11, 2'b10, 2'b01};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetA("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Uniform 10-cycle period: 10 edges per 100-cycle gate
    applyStimulus(1'b0, mk(10, 10, 10, 10, 1, 0));
    waitDrain(1'b0, 600);

    // Per-filter periods red 5, green 10, blue 20, clear 4
    per_by_sel = '{5, 4, 20, 10};
    sel_log.delete();
    applyStimulus(1'b0, mk(20, 10, 5, 25, 1, 0));
    waitDrain(1'b0, 600);
    checkOutput("A sel_count", sel_log.size(), 4, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("A sel_order[%0d]", i),
                  (i < sel_log.size()) ? int'(sel_log[i]) : -1, int'(exp_sel[i]), 0);
    end
    checkOutput("A s10_const", s_bad, 0, 0);

    // Abort in the blue gate: idle next cycle, no valid, outputs held
    per_by_sel = '{10, 10, 10, 10};
    startOnlyA(t0);
    waitCycle(t0 + 250);
    checkOutput("A blue_sel", s_a[3:2], 2, 0);
    checkOutput("A blue_oe_n", oe_a, 0, 0);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    checkOutput("A abort_s", s_a, 0, 0);
    checkOutput("A abort_oe_n", oe_a, 1, 0);
    repeat (450) @(negedge clk);
    checkOutput("A abort_busy", busy_a, 0, 0);
    checkOutput("A held_red", red_a, 20, 1);
    checkOutput("A held_green", green_a, 10, 1);
    checkOutput("A held_blue", blue_a, 5, 1);
    checkOutput("A held_clear", clear_a, 25, 1);
    checkOutput("A held_overflow", ovf_a, 0, 0);

    // start and abort together in IDLE: no scan
    @(negedge clk);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    checkOutput("A startabort_s", s_a, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("A startabort_busy", busy_a, 0, 0);

    // start held high: two back-to-back scans, 418 cycles apart, no third
    @(negedge clk);
    c0 = cyc;
    start_a = 1'b1;
    begin
      exp_t e1;
      exp_t e2;
      e1 = mk(10, 10, 10, 10, 1, 0);
      e1.vcyc = c0 + 1 + 417;
      e2 = e1;
      e2.vcyc = c0 + 1 + 417 + 418;
      q_a.push_back(e1);
      q_a.push_back(e2);
    end
    waitCycle(c0 + 1 + 418 + 5);
    start_a = 1'b0;
    waitDrain(1'b0, 1000);
    repeat (450) @(negedge clk);

    // Reset in the red gate clears everything asynchronously
    startOnlyA(t0);
    waitCycle(t0 + 50);
    #2 rst_n = 1'b0;
    #1 checkResetA("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, mk(10, 10, 10, 10, 1, 0));
    waitDrain(1'b0, 600);

    // Saturation: 300 edges per 600-cycle gate pin at 255 with overflow
    per_b = 2;
    applyStimulus(1'b1, mk(255, 255, 255, 255, 0, 1));
    waitDrain(1'b1, 3000);
    per_b = 10;
    applyStimulus(1'b1, mk(60, 60, 60, 60, 1, 0));
    waitDrain(1'b1, 3000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion by time 500000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
